// File: rtl/sub_pipe_64bits_pkg.sv
// ---------------------------------------------------------------------------
// sub_pipe_64bits_pkg
//
// Shared ALU definitions for the pipelined 64-bit subtractor: the datapath
// geometry, the packed per-stage pipeline register, and a small helper for
// the signed-overflow rule.
// ---------------------------------------------------------------------------
package sub_pipe_64bits_pkg;

    localparam int WIDTH  = 64;
    localparam int SLICE  = 16;
    localparam int NSLICE = 4;

    // One pipeline stage. The borrow is kept in true (borrow) polarity rather
    // than as the adder carry, so a cleared stage reads as "no borrow" and
    // the output register resets to bout = 0 without extra logic. remA/remB
    // are shifted right by one slice per stage, so the next slice to consume
    // is always in bits [SLICE-1:0].
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] diff;
        logic [WIDTH-1:0] remA;
        logic [WIDTH-1:0] remB;
        logic             borrow;
        logic             partZero;
        logic             signA;
        logic             signB;
        logic             ovf;
    } stage_t;

    // Signed overflow of a - b: operand signs differ and the result sign
    // disagrees with the minuend.
    function automatic logic overflowOf(input logic signA,
                                        input logic signB,
                                        input logic diffMsb);
        return (signA != signB) && (diffMsb != signA);
    endfunction

endpackage

// File: rtl/carry_lookahead_16bits.sv
// ---------------------------------------------------------------------------
// carry_lookahead_16bits
//
// Combinational 16-bit carry-lookahead adder: sum = a + b + cin.
// Two-level lookahead: four 4-bit groups produce group generate/propagate,
// the group carries are resolved in one lookahead level, then each group
// resolves its internal carries from its own group carry-in.
//
// Ports:
//   a, b  [15:0] in   addends
//   cin         in   carry-in
//   sum   [15:0] out  a + b + cin (low 16 bits)
//   cout        out  carry-out of bit 15
// ---------------------------------------------------------------------------
module carry_lookahead_16bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_groupG;
    logic [3:0]  w_groupP;
    logic [4:0]  w_groupC;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Group generate/propagate for each 4-bit nibble.
    always_comb begin
        w_groupG = '0;
        w_groupP = '0;
        for (int j = 0; j < 4; j++) begin
            w_groupG[j] = w_g[4*j+3]
                        | (w_p[4*j+3] & w_g[4*j+2])
                        | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                        | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
            w_groupP[j] = &w_p[4*j +: 4];
        end
    end

    // Group carries resolved in parallel from cin, no ripple between nibbles.
    always_comb begin
        w_groupC    = '0;
        w_groupC[0] = cin;
        w_groupC[1] = w_groupG[0] | (w_groupP[0] & cin);
        w_groupC[2] = w_groupG[1] | (w_groupP[1] & w_groupG[0])
                    | (w_groupP[1] & w_groupP[0] & cin);
        w_groupC[3] = w_groupG[2] | (w_groupP[2] & w_groupG[1])
                    | (w_groupP[2] & w_groupP[1] & w_groupG[0])
                    | (w_groupP[2] & w_groupP[1] & w_groupP[0] & cin);
        w_groupC[4] = w_groupG[3] | (w_groupP[3] & w_groupG[2])
                    | (w_groupP[3] & w_groupP[2] & w_groupG[1])
                    | (w_groupP[3] & w_groupP[2] & w_groupP[1] & w_groupG[0])
                    | (w_groupP[3] & w_groupP[2] & w_groupP[1] & w_groupP[0] & cin);
    end

    // Bit carries inside each nibble, expanded from the nibble's carry-in.
    always_comb begin
        w_c = '0;
        for (int j = 0; j < 4; j++) begin
            w_c[4*j]   = w_groupC[j];
            w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_groupC[j]);
            w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                       | (w_p[4*j+1] & w_p[4*j] & w_groupC[j]);
            w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                       | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                       | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_groupC[j]);
        end
    end

    assign sum  = w_p ^ w_c;
    assign cout = w_groupC[4];

endmodule

// File: rtl/sub_pipe_64bits.sv
// ---------------------------------------------------------------------------
// sub_pipe_64bits
//
// Four-stage pipelined 64-bit subtractor, d = a - b - bin (mod 2^64), one
// 16-bit slice per stage with the borrow registered between stages. Each
// slice is an adder computing a + ~b + ~borrow. Stage 4 is the output
// register; all results and flags come straight from its flops.
// A single advance enable moves the whole pipe, bubbles included.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand set present
//   in_ready   out  pipeline accepts this cycle (combinational)
//   a, b  [63:0] in minuend, subtrahend
//   bin        in   borrow-in
//   out_valid  out  result present
//   out_ready  in   consumer takes the result this cycle
//   d    [63:0] out difference
//   bout       out  borrow-out (unsigned a < b + bin)
//   ovf        out  signed overflow
//   zero       out  d == 0
// ---------------------------------------------------------------------------
module sub_pipe_64bits
    import sub_pipe_64bits_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    stage_t           r_stage  [NSLICE];
    stage_t           w_src    [NSLICE];
    stage_t           w_next   [NSLICE];
    logic [SLICE-1:0] w_opA    [NSLICE];
    logic [SLICE-1:0] w_opBInv [NSLICE];
    logic [SLICE-1:0] w_sum    [NSLICE];
    logic             w_cin    [NSLICE];
    logic             w_cout   [NSLICE];
    logic             w_adv;

    // The pipe moves as one unit: it advances unless a result is sitting in
    // the output register and nobody is taking it.
    assign w_adv    = ~r_stage[NSLICE-1].valid | out_ready;
    assign in_ready = w_adv;

    // Source of every slice computation. Slice 0 sees the ports dressed up as
    // a virtual "stage 0" (nothing computed yet, borrow = bin, zero so far =
    // true), so all four slices can share the same next-stage logic below.
    always_comb begin
        w_src[0]          = '0;
        w_src[0].valid    = in_valid & w_adv;
        w_src[0].remA     = a;
        w_src[0].remB     = b;
        w_src[0].borrow   = bin;
        w_src[0].partZero = 1'b1;
        w_src[0].signA    = a[WIDTH-1];
        w_src[0].signB    = b[WIDTH-1];
        for (int k = 1; k < NSLICE; k++) begin
            w_src[k] = r_stage[k-1];
        end
    end

    for (genvar k = 0; k < NSLICE; k++) begin : gSlice
        assign w_opA[k]    = w_src[k].remA[SLICE-1:0];
        assign w_opBInv[k] = ~w_src[k].remB[SLICE-1:0];
        assign w_cin[k]    = ~w_src[k].borrow;

        carry_lookahead_16bits uCla (
            .a    (w_opA[k]),
            .b    (w_opBInv[k]),
            .cin  (w_cin[k]),
            .sum  (w_sum[k]),
            .cout (w_cout[k])
        );
    end

    // Next value of each stage: merge this slice's sum into the partial
    // difference, drop the consumed operand bits, turn the adder carry back
    // into a borrow, and fold this slice into the running zero flag. Only
    // the last slice knows d[63], so overflow is formed there.
    always_comb begin
        for (int k = 0; k < NSLICE; k++) begin
            w_next[k]          = w_src[k];
            w_next[k].diff     = w_src[k].diff | (WIDTH'(w_sum[k]) << (SLICE * k));
            w_next[k].remA     = w_src[k].remA >> SLICE;
            w_next[k].remB     = w_src[k].remB >> SLICE;
            w_next[k].borrow   = ~w_cout[k];
            w_next[k].partZero = w_src[k].partZero & (w_sum[k] == '0);
            w_next[k].ovf      = (k == NSLICE - 1)
                               ? overflowOf(w_src[k].signA, w_src[k].signB,
                                            w_sum[k][SLICE-1])
                               : 1'b0;
        end
    end

    // Pipeline registers. Reset clears everything, which discards in-flight
    // operands and zeroes the output flags; a stall simply holds every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSLICE; k++) begin
                r_stage[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < NSLICE; k++) begin
                r_stage[k] <= w_next[k];
            end
        end
    end

    assign out_valid = r_stage[NSLICE-1].valid;
    assign d         = r_stage[NSLICE-1].diff;
    assign bout      = r_stage[NSLICE-1].borrow;
    assign ovf       = r_stage[NSLICE-1].ovf;
    assign zero      = r_stage[NSLICE-1].partZero;

endmodule

// File: tb/tb_sub_pipe_64bits.sv
// ---------------------------------------------------------------------------
// tb_sub_pipe_64bits
//
// Self-checking bench for sub_pipe_64bits. Expected results come from a
// plain 65-bit arithmetic reference; handshake timing is checked against
// the latency/stall rules of the block.
// ---------------------------------------------------------------------------
module tb_sub_pipe_64bits;

    typedef struct packed {
        logic [63:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;

    int total;
    int bad;

    sub_pipe_64bits dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact wide subtraction, borrow is the sign of the 65-bit result.
    function automatic res_t refSub(input logic [63:0] x, input logic [63:0] y,
                                    input logic bi);
        logic [64:0] full;
        res_t        r;
        full   = {1'b0, x} - {1'b0, y} - 65'(bi);
        r.d    = full[63:0];
        r.bout = full[64];
        r.ovf  = (x[63] != y[63]) && (r.d[63] != x[63]);
        r.zero = (r.d == 64'd0);
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Input driver only; no checking here.
    task automatic applyStimulus(input logic v, input logic [63:0] av,
                                 input logic [63:0] bv, input logic bi);
        in_valid = v;
        a        = av;
        b        = bv;
        bin      = bi;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b1, rand64(), rand64(), 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 64'd0, 64'd0, 1'b0);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        total++;
        if ({d, bout, ovf, zero} !== 67'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got d=%h bout=%b ovf=%b zero=%b expected all 0",
                     d, bout, ovf, zero);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    // Single operands through an empty pipe: exact 4-cycle latency and values.
    task automatic test_directed;
        logic [63:0] va [5];
        logic [63:0] vb [5];
        logic        vbin [5];
        res_t        exp;
        va[0] = 64'h10;                  vb[0] = 64'h3;                  vbin[0] = 1'b0;
        va[1] = 64'h0;                   vb[1] = 64'h1;                  vbin[1] = 1'b0;
        va[2] = 64'h5;                   vb[2] = 64'h4;                  vbin[2] = 1'b1;
        va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'h1;                  vbin[3] = 1'b0;
        va[4] = 64'h7FFF_FFFF_FFFF_FFFF; vb[4] = 64'hFFFF_FFFF_FFFF_FFFF; vbin[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            applyStimulus(1'b1, va[i], vb[i], vbin[i]);
            exp = refSub(va[i], vb[i], vbin[i]);
            @(negedge clk);
            applyStimulus(1'b0, rand64(), rand64(), 1'b0);
            repeat (2) @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL directed%0d_early: out_valid got %b expected 0", i, out_valid);
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL directed%0d_latency: out_valid got %b expected 1", i, out_valid);
            end
            total++;
            if ({d, bout, ovf, zero} !== exp) begin
                bad++;
                $display("[TB] FAIL directed%0d_result: got d=%h b=%b o=%b z=%b expected d=%h b=%b o=%b z=%b",
                         i, d, bout, ovf, zero, exp.d, exp.bout, exp.ovf, exp.zero);
            end
        end
    endtask

    task automatic test_back_to_back;
        res_t exp [8];
        logic [63:0] av;
        logic [63:0] bv;
        logic        bi;
        logic        expV;
        for (int t = 0; t < 13; t++) begin
            @(negedge clk);
            out_ready = 1'b1;
            expV = (t >= 4) && (t <= 11);
            total++;
            if (out_valid !== expV) begin
                bad++;
                $display("[TB] FAIL stream_valid_t%0d: got %b expected %b", t, out_valid, expV);
            end
            if (expV) begin
                total++;
                if ({d, bout, ovf, zero} !== exp[t-4]) begin
                    bad++;
                    $display("[TB] FAIL stream_result%0d: got d=%h b=%b o=%b z=%b expected d=%h b=%b o=%b z=%b",
                             t - 4, d, bout, ovf, zero, exp[t-4].d, exp[t-4].bout,
                             exp[t-4].ovf, exp[t-4].zero);
                end
            end
            if (t < 8) begin
                av = rand64();
                bv = rand64();
                bi = 1'($urandom_range(0, 1));
                exp[t] = refSub(av, bv, bi);
                applyStimulus(1'b1, av, bv, bi);
            end else begin
                applyStimulus(1'b0, 64'd0, 64'd0, 1'b0);
            end
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL stream_in_ready_t%0d: got %b expected 1", t, in_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        res_t exp [4];
        logic [63:0] av;
        logic [63:0] bv;
        logic        bi;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            out_ready = !((t >= 4) && (t <= 8));
            if (t < 4) begin
                av = rand64();
                bv = rand64();
                bi = 1'($urandom_range(0, 1));
                exp[t] = refSub(av, bv, bi);
                applyStimulus(1'b1, av, bv, bi);
            end else if (t <= 8) begin
                applyStimulus(1'b1, rand64(), rand64(), 1'b1);
            end else begin
                applyStimulus(1'b0, 64'd0, 64'd0, 1'b0);
            end
            #1;
            if ((t >= 4) && (t <= 8)) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL stall_in_ready_t%0d: got %b expected 0", t, in_ready);
                end
                total++;
                if ({out_valid, d, bout, ovf, zero} !== {1'b1, exp[0]}) begin
                    bad++;
                    $display("[TB] FAIL stall_hold_t%0d: got v=%b d=%h expected v=1 d=%h",
                             t, out_valid, d, exp[0].d);
                end
            end else if ((t >= 9) && (t <= 12)) begin
                total++;
                if ({out_valid, d, bout, ovf, zero} !== {1'b1, exp[t-9]}) begin
                    bad++;
                    $display("[TB] FAIL drain_result%0d: got v=%b d=%h b=%b o=%b z=%b expected v=1 d=%h b=%b o=%b z=%b",
                             t - 9, out_valid, d, bout, ovf, zero, exp[t-9].d,
                             exp[t-9].bout, exp[t-9].ovf, exp[t-9].zero);
                end
            end else if (t == 13) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL drain_extra: out_valid got %b expected 0", out_valid);
                end
            end
        end
    endtask

    task automatic test_reset_midop;
        logic [63:0] av;
        logic [63:0] bv;
        res_t        exp;
        for (int t = 0; t < 11; t++) begin
            @(negedge clk);
            out_ready = 1'b1;
            rst       = (t == 3);
            if (t <= 3) begin
                applyStimulus(1'b1, rand64(), rand64(), 1'($urandom_range(0, 1)));
            end else if (t == 5) begin
                av  = rand64();
                bv  = rand64();
                exp = refSub(av, bv, 1'b0);
                applyStimulus(1'b1, av, bv, 1'b0);
            end else begin
                applyStimulus(1'b0, 64'd0, 64'd0, 1'b0);
            end
            #1;
            if (t == 4) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready);
                end
            end
            if ((t >= 4) && (t != 9)) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL midrst_stale_t%0d: out_valid got %b expected 0", t, out_valid);
                end
            end else if (t == 9) begin
                total++;
                if ({out_valid, d, bout, ovf, zero} !== {1'b1, exp}) begin
                    bad++;
                    $display("[TB] FAIL midrst_result: got v=%b d=%h expected v=1 d=%h",
                             out_valid, d, exp.d);
                end
            end
        end
    endtask

    // Random valid/ready traffic against a FIFO of reference results.
    task automatic test_random_traffic;
        res_t        q [$];
        res_t        exp;
        logic [63:0] av;
        logic [63:0] bv;
        logic        bi;
        logic        expReady;
        int          guard;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            av = rand64();
            bv = ($urandom_range(0, 7) == 0) ? av : rand64();
            bi = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) bv = 64'hFFFF_FFFF_FFFF_FFFF;
            applyStimulus(($urandom_range(0, 2) != 0), av, bv, bi);
            #1;
            expReady = !out_valid || out_ready;
            total++;
            if (in_ready !== expReady) begin
                bad++;
                $display("[TB] FAIL rand_in_ready_c%0d: got %b expected %b", cyc, in_ready, expReady);
            end
            if (out_valid === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL rand_spurious_c%0d: got out_valid=1 expected no pending result", cyc);
                end else begin
                    exp = q[0];
                    if ({d, bout, ovf, zero} !== exp) begin
                        bad++;
                        $display("[TB] FAIL rand_result_c%0d: got d=%h b=%b o=%b z=%b expected d=%h b=%b o=%b z=%b",
                                 cyc, d, bout, ovf, zero, exp.d, exp.bout, exp.ovf, exp.zero);
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && expReady) q.push_back(refSub(av, bv, bi));
        end
        applyStimulus(1'b0, 64'd0, 64'd0, 1'b0);
        guard = 0;
        while ((q.size() != 0) && (guard < 20)) begin
            @(negedge clk);
            out_ready = 1'b1;
            guard++;
            if (out_valid === 1'b1) begin
                exp = q.pop_front();
                total++;
                if ({d, bout, ovf, zero} !== exp) begin
                    bad++;
                    $display("[TB] FAIL rand_drain: got d=%h expected d=%h", d, exp.d);
                end
            end
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("[TB] FAIL rand_lost: got %0d results still pending expected 0", q.size());
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, 64'd0, 64'd0, 1'b0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_random_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_pipe_64bits.md
# sub_pipe_64bits

Four-stage pipelined 64-bit subtractor computing d = a − b − bin, one 16-bit slice per stage with the borrow registered between stages. It is the inverse-direction companion to the combinational 64-bit carry-lookahead adder. The datapath reuses the 16-bit carry-lookahead slice and adds valid/ready handshakes for sustained one-per-cycle throughput in the ALU datapath. It also produces the flags the branch/compare logic needs: borrow, signed overflow and zero.

## Interface
- No parameters; width fixed at 64 bits, 4 slices of 16 bits.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  pipeline can accept this cycle.
- a  input  64  minuend.
- b  input  64  subtrahend.
- bin  input  1  borrow-in, for chaining wider subtractions.
- out_valid  output  1  result present at output register.
- out_ready  input  1  consumer accepts result this cycle.
- d  output  64  difference a − b − bin, modulo 2^64.
- bout  output  1  borrow-out; 1 iff unsigned a < b + bin.
- ovf  output  1  signed overflow: a[63] ≠ b[63] and d[63] ≠ a[63].
- zero  output  1  d == 0.

## Operation
- Subtraction is done as addition: each slice computes a_slice + ~b_slice + c.
  - Slice 0 carry-in is ~bin.
  - Slice k carry-in is the registered carry-out of slice k−1.
  - bout = ~(carry-out of slice 3).
- Pipeline stages S1..S4 each hold:
  - a valid bit;
  - the low 16·k result bits computed so far;
  - the unconsumed upper a/b bits;
  - the pending carry;
  - a partial zero flag (AND of slice-zero results so far).
- S1 captures slice 0 computed combinationally from the port inputs. S2–S4 compute slices 1–3 from the previous stage.
- S4 is the output register. d, bout, ovf and zero are driven directly from S4 flops, not combinationally.
- ovf is evaluated in stage 4 from a[63], b[63] (carried forward) and d[63].
- Global advance enable: adv = ~out_valid | out_ready.
  - All stages shift together when adv = 1 and hold when adv = 0.
  - Bubbles are carried, not collapsed.
- in_ready = adv, computed combinationally. An accept is in_valid & in_ready.
- A stage's valid bit loads the previous stage's valid bit on adv. S1 loads in_valid & in_ready.
- Data flops of an invalid stage may hold stale values. Outputs are meaningful only while out_valid = 1.

## Timing
- Latency: an operand accepted at edge N appears with out_valid = 1 after edge N+3. Four register stages, including the output register.
- Throughput: one result per cycle while out_ready stays high.
- Stall: out_valid & ~out_ready freezes every stage and deasserts in_ready in the same cycle. d and flags stay stable until the transfer completes.
- A transfer at the output and an accept at the input in the same cycle are both legal. This is the normal streaming case.
- Reset, when rst = 1 at an edge:
  - all valid bits go to 0;
  - d, bout, ovf and zero go to 0;
  - in-flight operands are discarded, with no partial results emitted;
  - in_ready is 1 in the first cycle after reset.
- Inputs presented while rst = 1 are ignored.
- Wrap-around: d is modulo 2^64. bout and ovf flag the wrap and are never saturated.

## Structure
- One sub-module, carry_lookahead_16bits (existing), instantiated four times, once per stage, with inverted b.
- Shared ALU package holds:
  - WIDTH = 64, SLICE = 16, NSLICE = 4;
  - a packed stage-register typedef: valid, partial d, remaining a/b, carry, partial zero, a[63]/b[63] sign bits.
- Pipeline registers and handshake logic live in the top module.

## Test plan
- Basic: a = 0x10, b = 0x3, bin = 0, out_ready = 1 → 4 cycles later d = 0xD, bout = 0, ovf = 0, zero = 0.
- Borrow across all slices: a = 0, b = 1 → d = 0xFFFF_FFFF_FFFF_FFFF, bout = 1, ovf = 0. Then a = 5, b = 4, bin = 1 → d = 0, zero = 1, bout = 0.
- Signed overflow: a = 0x8000_0000_0000_0000, b = 1 → d = 0x7FFF_FFFF_FFFF_FFFF, ovf = 1, bout = 0. Also a = 0x7FFF_FFFF_FFFF_FFFF, b = 0xFFFF_FFFF_FFFF_FFFF → ovf = 1, bout = 1.
- Streaming: 8 back-to-back random operands with out_ready = 1 → 8 consecutive out_valid cycles starting at the 4th cycle, results in order and matching the reference a − b − bin.
- Backpressure: hold out_ready = 0 for 5 cycles once the pipeline is full → in_ready = 0, d and flags stable. Release → all 4 results drain in order, with none lost or duplicated.
- Reset mid-operation: accept 3 operands, assert rst for 1 cycle → out_valid stays 0 with no stale result emitted. The next accepted operand emerges after exactly 4 cycles.
